// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cipher_pkg
// Purpose  : Shared alphabet constants, symbol type and modular add/sub
//            helpers for the rotor cipher, keypad encoder and display blocks.
// Revision : 1.0 - initial release
// ============================================================================
package cipher_pkg;

  // Default alphabet: A-Z followed by 0-9.
  localparam int unsigned SYM_W   = 6;
  localparam int unsigned MODULUS = 36;

  typedef logic [SYM_W-1:0] sym_t;

  // (a + b) mod m, valid when a < m and b < m (a single conditional subtract).
  function automatic int unsigned mod_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    int unsigned t;
    t = a + b;
    if (t >= m) begin
      t = t - m;
    end
    return t;
  endfunction

  // (a - b) mod m, valid when a < m and b < m.
  function automatic int unsigned mod_sub(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    int unsigned t;
    if (a >= b) begin
      t = a - b;
    end else begin
      t = a + m - b;
    end
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rotor_cipher_stream_rotor_bank.sv
`default_nettype none
// ============================================================================
// Module   : rotor_bank
// Purpose  : Odometer-style bank of rotor position registers. Loads from the
//            key, steps rotor 0 on request with a ripple carry into higher
//            rotors, and presents the sum of all positions as offset k.
// Revision : 1.0 - initial release
// ============================================================================
module rotor_bank
  import cipher_pkg::*;
#(
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned ROTOR_W    = 3,
  parameter int unsigned K_W        = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ROTORS*ROTOR_W-1:0] key,
  input  logic                          key_load,
  input  logic                          step,
  output logic [K_W-1:0]                k,
  output logic [NUM_ROTORS*ROTOR_W-1:0] rotor_pos
);

  localparam logic [ROTOR_W-1:0] c_ROTOR_MAX = {ROTOR_W{1'b1}};

  logic [NUM_ROTORS*ROTOR_W-1:0] r_pos;
  logic [NUM_ROTORS-1:0]         w_carry;
  logic [K_W-1:0]                w_sum;

  // Carry chain: rotor i advances when every lower rotor is at max during a step.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = step;
    for (int i = 1; i < NUM_ROTORS; i++) begin
      w_carry[i] = w_carry[i-1] && (r_pos[(i-1)*ROTOR_W +: ROTOR_W] == c_ROTOR_MAX);
    end
  end

  // Offset k is the plain sum of positions; the width constraint keeps it below MODULUS.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_ROTORS; i++) begin
      w_sum = w_sum + K_W'(r_pos[i*ROTOR_W +: ROTOR_W]);
    end
  end

  // Rotor registers: key load wins, otherwise advance the rotors selected by the carry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pos <= '0;
    end else if (key_load) begin
      r_pos <= key;
    end else begin
      for (int i = 0; i < NUM_ROTORS; i++) begin
        if (w_carry[i]) begin
          r_pos[i*ROTOR_W +: ROTOR_W] <= r_pos[i*ROTOR_W +: ROTOR_W] + 1'b1;
        end
      end
    end
  end

  assign k         = w_sum;
  assign rotor_pos = r_pos;

endmodule
`default_nettype wire

// File: rtl/rotor_cipher_stream.sv
`default_nettype none
// ============================================================================
// Module   : rotor_cipher_stream
// Purpose  : Streaming multi-rotor substitution cipher. Encrypts or decrypts
//            one symbol per accepted valid/ready transfer with a registered,
//            back-pressurable output and an invalid-symbol flag.
// Options  : ROTOR_CIPHER_AUTOKEY_EN - adds the previous plaintext symbol
//            into the offset (autokey chaining).
// Revision : 1.0 - initial release
// ============================================================================
module rotor_cipher_stream
  import cipher_pkg::*;
#(
  parameter int unsigned SYM_W      = cipher_pkg::SYM_W,
  parameter int unsigned MODULUS    = cipher_pkg::MODULUS,
  parameter int unsigned NUM_ROTORS = 3,
  parameter int unsigned ROTOR_W    = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ROTORS*ROTOR_W-1:0] key,
  input  logic                          key_load,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [SYM_W-1:0]              din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SYM_W-1:0]              dout,
  output logic                          out_err,
  output logic [NUM_ROTORS*ROTOR_W-1:0] rotor_pos,
  output logic [15:0]                   sym_count
);

  localparam logic [SYM_W:0] c_MOD = (SYM_W+1)'(MODULUS);

  // Reject configurations whose alphabet or rotor offsets do not fit.
  if (MODULUS > (2 ** SYM_W)) begin : g_bad_modulus
    $error("rotor_cipher_stream: MODULUS exceeds 2**SYM_W");
  end
  if (NUM_ROTORS * ((2 ** ROTOR_W) - 1) >= MODULUS) begin : g_bad_rotors
    $error("rotor_cipher_stream: rotor offset sum can reach MODULUS");
  end

  logic             r_out_valid;
  logic [SYM_W-1:0] r_dout;
  logic             r_out_err;
  logic [15:0]      r_sym_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_sym_ok;
  logic             w_step;
  logic [SYM_W-1:0] w_k;
  logic [SYM_W-1:0] w_off;
  logic [SYM_W-1:0] w_enc;
  logic [SYM_W-1:0] w_dec;
  logic [SYM_W-1:0] w_result;

  // A new symbol may enter when the output slot is empty or being drained,
  // except during a key load cycle.
  assign w_in_ready = !key_load && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_sym_ok   = ({1'b0, din} < c_MOD);
  assign w_step     = w_accept && w_sym_ok;

  rotor_bank #(
    .NUM_ROTORS (NUM_ROTORS),
    .ROTOR_W    (ROTOR_W),
    .K_W        (SYM_W)
  ) u_rotor_bank (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .key_load  (key_load),
    .step      (w_step),
    .k         (w_k),
    .rotor_pos (rotor_pos)
  );

`ifdef ROTOR_CIPHER_AUTOKEY_EN
  logic [SYM_W-1:0] r_prev_plain;

  assign w_off = SYM_W'(mod_add(32'(w_k), 32'(r_prev_plain), MODULUS));

  // Autokey chain: remember the plaintext of the last valid symbol.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_plain <= '0;
    end else if (key_load) begin
      r_prev_plain <= '0;
    end else if (w_step) begin
      r_prev_plain <= mode ? din : w_dec;
    end
  end
`else
  assign w_off = w_k;
`endif

  assign w_enc    = SYM_W'(mod_add(32'(din), 32'(w_off), MODULUS));
  assign w_dec    = SYM_W'(mod_sub(32'(din), 32'(w_off), MODULUS));
  assign w_result = mode ? w_enc : w_dec;

  // Output holding register: load on accept, clear valid once drained.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_dout      <= w_sym_ok ? w_result : din;
      r_out_err   <= !w_sym_ok;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Count of valid symbols accepted since reset or the last key load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sym_count <= '0;
    end else if (key_load) begin
      r_sym_count <= '0;
    end else if (w_step) begin
      r_sym_count <= r_sym_count + 16'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign out_err   = r_out_err;
  assign sym_count = r_sym_count;

endmodule
`default_nettype wire

// File: tb/tb_rotor_cipher_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_rotor_cipher_stream
// Purpose  : Self-checking bench for rotor_cipher_stream: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rotor_cipher_stream;

  localparam int SW = 6;
  localparam int M  = 36;
  localparam int NR = 3;
  localparam int RW = 3;
  localparam int KW = NR * RW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [KW-1:0] key = '0;
  logic          key_load = 1'b0;
  logic          mode = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] din = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [SW-1:0] dout;
  logic          out_err;
  logic [KW-1:0] rotor_pos;
  logic [15:0]   sym_count;

  always #5 clk = ~clk;

  rotor_cipher_stream #(
    .SYM_W      (SW),
    .MODULUS    (M),
    .NUM_ROTORS (NR),
    .ROTOR_W    (RW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key       (key),
    .key_load  (key_load),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_err   (out_err),
    .rotor_pos (rotor_pos),
    .sym_count (sym_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_rot[NR];
  int m_cnt;
  bit m_valid;
  int m_dout;
  bit m_err;
  int m_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) m_rot[i] = 0;
    m_cnt   = 0;
    m_valid = 1'b0;
    m_dout  = 0;
    m_err   = 1'b0;
    m_prev  = 0;
  endfunction

  function automatic bit m_ready();
    return !key_load && (!m_valid || out_ready);
  endfunction

  function automatic int m_offset();
    int k = 0;
    for (int i = 0; i < NR; i++) k += m_rot[i];
`ifdef ROTOR_CIPHER_AUTOKEY_EN
    k += m_prev;
`endif
    return k % M;
  endfunction

  function automatic logic [KW-1:0] m_pos();
    logic [KW-1:0] p = '0;
    for (int i = 0; i < NR; i++) p[i*RW +: RW] = RW'(m_rot[i]);
    return p;
  endfunction

  // Apply one rising edge to the model with the currently driven inputs.
  function automatic void m_edge();
    bit acc;
    int d, off, t;
    acc = in_valid && m_ready();
    if (key_load) begin
      for (int i = 0; i < NR; i++) m_rot[i] = int'(key[i*RW +: RW]);
      m_cnt  = 0;
      m_prev = 0;
    end
    if (acc) begin
      d       = int'(din);
      m_valid = 1'b1;
      if (d >= M) begin
        m_dout = d;
        m_err  = 1'b1;
      end else begin
        off    = m_offset();
        t      = mode ? (d + off) % M : (d - off + M) % M;
        m_dout = t;
        m_err  = 1'b0;
        m_prev = mode ? d : t;
        m_cnt  = (m_cnt + 1) % 65536;
        for (int i = 0; i < NR; i++) begin
          m_rot[i]++;
          if (m_rot[i] < (1 << RW)) break;
          m_rot[i] = 0;
        end
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  // One clock: check in_ready, advance the model, compare all outputs after the edge.
  task automatic tick(input string tag);
    #1;
    check_eq({tag, "/in_ready"}, 32'(in_ready), 32'(m_ready()));
    m_edge();
    @(posedge clk);
    #1;
    check_eq({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
    check_eq({tag, "/dout"},      32'(dout),      m_dout);
    check_eq({tag, "/out_err"},   32'(out_err),   32'(m_err));
    check_eq({tag, "/rotor_pos"}, 32'(rotor_pos), 32'(m_pos()));
    check_eq({tag, "/sym_count"}, 32'(sym_count), m_cnt);
    @(negedge clk);
  endtask

  task automatic load_key(input logic [KW-1:0] kv);
    key      = kv;
    key_load = 1'b1;
    in_valid = 1'b0;
    tick("key_load");
    key_load = 1'b0;
  endtask

  task automatic send(input string tag, input bit md, input int sym);
    mode     = md;
    din      = SW'(sym);
    in_valid = 1'b1;
    tick(tag);
    in_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst/out_valid", 32'(out_valid), 0);
    check_eq("rst/dout",      32'(dout), 0);
    check_eq("rst/out_err",   32'(out_err), 0);
    check_eq("rst/rotor_pos", 32'(rotor_pos), 0);
    check_eq("rst/sym_count", 32'(sym_count), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Encrypt with key {3,2,1}
    out_ready = 1'b1;
    load_key({3'd3, 3'd2, 3'd1});
    send("enc5", 1'b1, 5);
`ifndef ROTOR_CIPHER_AUTOKEY_EN
    check_eq("plan/enc5", 32'(dout), 11);
`endif
    send("enc35", 1'b1, 35);
`ifndef ROTOR_CIPHER_AUTOKEY_EN
    check_eq("plan/enc35", 32'(dout), 6);
`endif
    check_eq("plan/r0_after", 32'(rotor_pos[2:0]), 3);

    // Decrypt with the same key reloaded
    load_key({3'd3, 3'd2, 3'd1});
    send("dec3", 1'b0, 3);
    check_eq("plan/dec3", 32'(dout), 33);
    check_eq("plan/dec3_err", 32'(out_err), 0);

    // Double carry
    load_key({3'd0, 3'd7, 3'd7});
    send("carry", 1'b1, 0);
    check_eq("plan/double_carry", 32'(rotor_pos), 32'(9'b001_000_000));

    // Invalid symbol
    send("invalid", 1'b1, 40);
    check_eq("plan/inv_dout", 32'(dout), 40);
    check_eq("plan/inv_err", 32'(out_err), 1);
    check_eq("plan/inv_pos", 32'(rotor_pos), 32'(9'b001_000_000));
    check_eq("plan/inv_count", 32'(sym_count), 1);

    // Backpressure: two symbols offered while downstream stalls
    in_valid = 1'b0;
    tick("drain");
    out_ready = 1'b0;
    mode      = 1'b1;
    din       = 6'd1;
    in_valid  = 1'b1;
    tick("bp_first");
    din = 6'd2;
    #1;
    check_eq("plan/bp_ready_low", 32'(in_ready), 0);
    tick("bp_hold");
    check_eq("plan/bp_count_once", 32'(sym_count), 2);
    check_eq("plan/bp_held_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick("bp_release");
    check_eq("plan/bp_second_count", 32'(sym_count), 3);
    in_valid = 1'b0;

    // Asynchronous reset while output is pending
    out_ready = 1'b0;
    send("pre_rst", 1'b1, 7);
    check_eq("plan/pre_rst_valid", 32'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst/out_valid", 32'(out_valid), 0);
    check_eq("arst/dout",      32'(dout), 0);
    check_eq("arst/rotor_pos", 32'(rotor_pos), 0);
    check_eq("arst/sym_count", 32'(sym_count), 0);
    m_reset();
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef ROTOR_CIPHER_AUTOKEY_EN
    load_key('0);
    send("ak1", 1'b1, 1);
    check_eq("plan/autokey1", 32'(dout), 1);
    send("ak2", 1'b1, 1);
    check_eq("plan/autokey2", 32'(dout), 3);
`endif

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      key_load  = ($urandom_range(0, 19) == 0);
      key       = KW'($urandom_range(0, (1 << KW) - 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      din       = SW'($urandom_range(0, (1 << SW) - 1));
      mode      = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 6);
      tick("rnd");
    end
    key_load = 1'b0;
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
